immgen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. It takes one raw instruction per cycle with its PC, classifies the encoding format, and builds the sign- or zero-extended immediate for every RV32I/RV64I format (I, S, B, U, J, shift-amount, CSR zimm). It also computes the PC-relative target `pc + imm`. Results pass through a valid/ready skid buffer, so decode can stall or flush without losing or duplicating an instruction.

---
 rtl/immgen_pkg.sv | 107 ++++++++++
 rtl/immgen_skid.sv | 78 +++++++
 rtl/immgen_pipe.sv | 62 ++++++
 tb/tb_immgen_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared types, opcode constants and the combinational immediate decoder
// used by the immgen_pipe decode-stage block.
package immgen_pkg;

  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtZ   = 3'd6,
    FmtIll = 3'd7
  } imm_fmt_e;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OPIMM32  = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam int unsigned MaxXlen = 64;

  // Immediate is always built at 64 bits; callers truncate to their XLEN.
  typedef struct packed {
    logic [MaxXlen-1:0] imm;
    imm_fmt_e           fmt;
  } imm_res_t;

  function automatic imm_res_t decode_imm(input logic [31:0] ins, input int unsigned xlen);
    imm_res_t           res;
    logic               is64;
    logic               is_shift;
    logic [MaxXlen-1:0] i_imm;
    is64     = (xlen == 64);
    // funct3 001 (SLLI) or 101 (SRLI/SRAI)
    is_shift = (ins[13:12] == 2'b01);
    i_imm    = {{52{ins[31]}}, ins[31:20]};
    res.imm  = '0;
    res.fmt  = FmtIll;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
          res.fmt = FmtI;
          res.imm = i_imm;
        end
        OPC_OPIMM: begin
          if (!is_shift) begin
            res.fmt = FmtI;
            res.imm = i_imm;
          end else if (is64) begin
            res.fmt = FmtI;
            res.imm = {58'b0, ins[25:20]};
          end else if (!ins[25]) begin
            res.fmt = FmtI;
            res.imm = {59'b0, ins[24:20]};
          end
        end
        OPC_OPIMM32: begin
          if (is64) begin
            res.fmt = FmtI;
            res.imm = is_shift ? {59'b0, ins[24:20]} : i_imm;
          end
        end
        OPC_STORE: begin
          res.fmt = FmtS;
          res.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        end
        OPC_BRANCH: begin
          res.fmt = FmtB;
          res.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          res.fmt = FmtU;
          res.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
        end
        OPC_JAL: begin
          res.fmt = FmtJ;
          res.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          res.fmt = FmtZ;
          res.imm = {59'b0, ins[19:15]};
        end
        OPC_OP: begin
          res.fmt = FmtR;
        end
        OPC_OP32: begin
          if (is64) begin
            res.fmt = FmtR;
          end
        end
        default: ;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/immgen_skid.sv
// Generic two-entry valid/ready skid buffer. The upstream ready is a pure
// register output so there is no combinational path from i_ready to o_ready.
module immgen_skid
  import immgen_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_main_valid;
  logic [Width-1:0] r_main_data;
  logic             r_skid_valid;
  logic [Width-1:0] r_skid_data;

  logic             w_main_valid_nxt;
  logic [Width-1:0] w_main_data_nxt;
  logic             w_skid_valid_nxt;
  logic [Width-1:0] w_skid_data_nxt;
  logic             w_accept;
  logic             w_drain;

  assign w_accept = i_valid && !r_skid_valid;
  assign w_drain  = r_main_valid && i_ready;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (i_flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_drain) begin
      // Skid full implies no accept this cycle, so the two branches are exclusive.
      if (r_skid_valid) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = r_skid_data;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_valid_nxt = w_accept;
        if (w_accept) begin
          w_main_data_nxt = i_data;
        end
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  assign o_ready = !r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

endmodule

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator: combinational decode and PC-relative adder
// feeding a two-entry skid buffer with one cycle of latency.
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PCW  = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [PCW-1:0]  in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PCW-1:0]  out_pc,
  output logic [PCW-1:0]  out_target
);

  localparam int unsigned PayloadW = XLEN + 3 + 1 + 2 * PCW;

  imm_res_t            w_dec;
  logic [PCW-1:0]      w_target;
  logic                w_illegal;
  logic [PayloadW-1:0] w_in_payload;
  logic [PayloadW-1:0] w_out_payload;
  logic                w_unused_imm;

  always_comb begin
    w_dec     = decode_imm(in_ins, XLEN);
    w_illegal = (w_dec.fmt == FmtIll);
    // The 64-bit immediate is already sign-extended, so slicing is a modular add.
    w_target  = in_pc + w_dec.imm[PCW-1:0];
  end

  // Upper immediate bits are only meaningful for the widest configuration.
  assign w_unused_imm = ^w_dec.imm;

  assign w_in_payload = {w_dec.imm[XLEN-1:0], w_dec.fmt, w_illegal, in_pc, w_target};

  immgen_skid #(
    .Width(PayloadW)
  ) u_skid (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_flush(flush),
    .i_valid(in_valid),
    .o_ready(in_ready),
    .i_data (w_in_payload),
    .o_valid(out_valid),
    .i_ready(out_ready),
    .o_data (w_out_payload)
  );

  assign {out_imm, out_fmt, out_illegal, out_pc, out_target} = w_out_payload;

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench for immgen_pipe: XLEN=32 and XLEN=64 instances driven with
// directed vectors; a negedge monitor pops expected results as beats drain.
module tb_immgen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_valid32 = 1'b0;
  logic        in_valid64 = 1'b0;
  logic [31:0] in_ins = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready32, o32_valid, o32_illegal;
  logic [31:0] o32_imm, o32_pc, o32_target;
  logic [2:0]  o32_fmt;
  logic        in_ready64, o64_valid, o64_illegal;
  logic [63:0] o64_imm, o64_pc, o64_target;
  logic [2:0]  o64_fmt;

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .PCW(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_ins(in_ins), .in_pc(in_pc[31:0]),
    .out_valid(o32_valid), .out_ready(out_ready), .out_imm(o32_imm), .out_fmt(o32_fmt),
    .out_illegal(o32_illegal), .out_pc(o32_pc), .out_target(o32_target)
  );

  immgen_pipe #(.XLEN(64), .PCW(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(o64_valid), .out_ready(out_ready), .out_imm(o64_imm), .out_fmt(o64_fmt),
    .out_illegal(o64_illegal), .out_pc(o64_pc), .out_target(o64_target)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Offer one instruction, wait (bounded) for acceptance, queue the expectation.
  task automatic send(input bit w64, input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic [63:0] tgt);
    exp_t e;
    int   n;
    bit   ok;
    in_ins = ins;
    in_pc  = pc;
    if (w64) in_valid64 = 1'b1;
    else     in_valid32 = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = w64 ? in_ready64 : in_ready32;
      n++;
    end
    if (!ok) begin
      chk("send_timeout", 64'(ok), 64'd1);
    end else begin
      e.imm = w64 ? imm : {32'b0, imm[31:0]};
      e.fmt = fmt;
      e.ill = (fmt == 3'd7);
      e.pc  = w64 ? pc : {32'b0, pc[31:0]};
      e.tgt = w64 ? tgt : {32'b0, tgt[31:0]};
      if (w64) q64.push_back(e);
      else     q32.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q32_empty", 64'(q32.size()), 64'd0);
    chk("drain_q64_empty", 64'(q64.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o32_valid && out_ready) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out32_unexpected: got beat with pc 0x%0h, required none", o32_pc);
      end else begin
        e = q32.pop_front();
        chk("out32_imm", 64'(o32_imm), e.imm);
        chk("out32_fmt", 64'(o32_fmt), 64'(e.fmt));
        chk("out32_illegal", 64'(o32_illegal), 64'(e.ill));
        chk("out32_pc", 64'(o32_pc), e.pc);
        chk("out32_target", 64'(o32_target), e.tgt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o64_valid && out_ready) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out64_unexpected: got beat with pc 0x%0h, required none", o64_pc);
      end else begin
        e = q64.pop_front();
        chk("out64_imm", o64_imm, e.imm);
        chk("out64_fmt", 64'(o64_fmt), 64'(e.fmt));
        chk("out64_illegal", 64'(o64_illegal), 64'(e.ill));
        chk("out64_pc", o64_pc, e.pc);
        chk("out64_target", o64_target, e.tgt);
      end
    end
  end

  // Outputs must hold while stalled (valid and not ready, no flush in between).
  bit          p_hold = 1'b0;
  logic [31:0] p_imm, p_pc, p_tgt;
  logic [2:0]  p_fmt;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", 64'(o32_valid), 64'd1);
        chk("hold_imm", 64'(o32_imm), 64'(p_imm));
        chk("hold_fmt", 64'(o32_fmt), 64'(p_fmt));
        chk("hold_pc", 64'(o32_pc), 64'(p_pc));
        chk("hold_target", 64'(o32_target), 64'(p_tgt));
      end
      p_hold = o32_valid && !out_ready && !flush;
      p_imm  = o32_imm;
      p_fmt  = o32_fmt;
      p_pc   = o32_pc;
      p_tgt  = o32_target;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_out_valid", 64'(o32_valid), 64'd0);
    chk("rst_out_imm", 64'(o32_imm), 64'd0);
    chk("rst_out_target", 64'(o32_target), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst64_out_valid", 64'(o64_valid), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic formats, XLEN=32
    send(0, 32'hFFF00093, 64'h100, 64'hFFFFFFFF, 3'd1, 64'hFF);
    chk("latency_valid", 64'(o32_valid), 64'd1);
    send(0, 32'hFE000EE3, 64'h100, 64'hFFFFFFFC, 3'd3, 64'hFC);
    send(0, 32'h001000EF, 64'h100, 64'h800, 3'd5, 64'h900);
    send(0, 32'h02009093, 64'h300, 64'h0, 3'd7, 64'h300);
    send(0, 32'h00000000, 64'h304, 64'h0, 3'd7, 64'h304);
    send(0, 32'h00509093, 64'h0, 64'h5, 3'd1, 64'h5);
    send(0, 32'hFE20AE23, 64'h200, 64'hFFFFFFFC, 3'd2, 64'h1FC);
    send(0, 32'h300FD073, 64'h0, 64'h1F, 3'd6, 64'h1F);
    send(0, 32'h002081B3, 64'h40, 64'h0, 3'd0, 64'h40);
    send(0, 32'h12345037, 64'h10, 64'h12345000, 3'd4, 64'h12345010);
    send(0, 32'h002081BB, 64'h50, 64'h0, 3'd7, 64'h50);
    send(0, 32'h001000EF, 64'hFFFFFF00, 64'h800, 3'd5, 64'h700);

    // XLEN=64
    send(1, 32'h80000037, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80001000);
    send(1, 32'h03F09093, 64'h0, 64'h3F, 3'd1, 64'h3F);
    send(1, 32'hFFF0009B, 64'h20, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h1F);
    send(1, 32'h0010909B, 64'h0, 64'h1, 3'd1, 64'h1);
    send(1, 32'h002081BB, 64'h30, 64'h0, 3'd0, 64'h30);
    send(1, 32'h001000EF, 64'hFFFFFFFFFFFFFFF0, 64'h800, 3'd5, 64'h7F0);
    drain();

    // Stall: out_ready low for three edges while four beats stream in
    out_ready = 1'b0;
    send(0, 32'h00100093, 64'h1000, 64'h1, 3'd1, 64'h1001);
    chk("stall_ready_after_1", 64'(in_ready32), 64'd1);
    send(0, 32'h00200093, 64'h1004, 64'h2, 3'd1, 64'h1006);
    chk("stall_ready_after_2", 64'(in_ready32), 64'd0);
    fork
      send(0, 32'h00300093, 64'h1008, 64'h3, 3'd1, 64'h100B);
      begin
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(0, 32'h00400093, 64'h100C, 64'h4, 3'd1, 64'h1010);
    drain();

    // Flush with both entries full and a beat offered in the flush cycle
    out_ready = 1'b0;
    send(0, 32'h00500093, 64'h2000, 64'h5, 3'd1, 64'h2005);
    send(0, 32'h00600093, 64'h2004, 64'h6, 3'd1, 64'h200A);
    flush = 1'b1;
    in_valid32 = 1'b1;
    in_ins = 32'h00700093;
    in_pc = 64'h2008;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid32 = 1'b0;
    chk("flush_out_valid", 64'(o32_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready32), 64'd1);
    q32.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Flush with only main occupied: the offered beat is dropped despite in_ready=1
    out_ready = 1'b0;
    send(0, 32'h00800093, 64'h3000, 64'h8, 3'd1, 64'h3008);
    flush = 1'b1;
    in_valid32 = 1'b1;
    in_ins = 32'h00900093;
    in_pc = 64'h3004;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid32 = 1'b0;
    chk("flush2_out_valid", 64'(o32_valid), 64'd0);
    q32.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(0, 32'h00A00093, 64'h3100, 64'hA, 3'd1, 64'h310A);
    drain();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(0, 32'h00B00093, 64'h4000, 64'hB, 3'd1, 64'h400B);
    send(0, 32'h00C00093, 64'h4004, 64'hC, 3'd1, 64'h4010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(o32_valid), 64'd0);
    chk("arst_out_imm", 64'(o32_imm), 64'd0);
    chk("arst_out_fmt", 64'(o32_fmt), 64'd0);
    chk("arst_out_illegal", 64'(o32_illegal), 64'd0);
    chk("arst_out_pc", 64'(o32_pc), 64'd0);
    chk("arst_out_target", 64'(o32_target), 64'd0);
    chk("arst_in_ready", 64'(in_ready32), 64'd1);
    q32.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(0, 32'hFFF00093, 64'h5000, 64'hFFFFFFFF, 3'd1, 64'h4FFF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
